// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, the bubble instruction and fetch FSM states.
// Pure declarations; no timing or flow control.
package cpu_pkg;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_ALU  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_BR   = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0101;
  localparam logic [3:0] OP_NOP  = 4'b1000;

  // Bubble word: opcode 1000 decodes to all-zero controls, unlike 0000 (halt).
  localparam logic [15:0] NOP_INSTR = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: address/request out, word/valid back.
// Memory answers combinationally; a cycle without imem_valid stalls fetch.
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_addr, imem_req, input imem_rdata, imem_valid);
  modport slave  (input imem_addr, imem_req, output imem_rdata, imem_valid);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold, load and bubble controls (bubble wins over load).
// One-cycle latency; holds its contents when neither load nor bubble is asserted.
module if_id_reg #(
  parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc2_in,
  output logic [15:0] instr,
  output logic [15:0] pc2,
  output logic        valid
);

  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc2_d   = pc2_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc2_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc2   = pc2_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, RUN/WAIT/HALTED FSM, memory-wait watchdog and IF/ID register.
// Fetch-to-IF/ID latency 1 cycle; stall or missing imem_valid holds the PC.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = cpu_pkg::NOP_INSTR,
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 if_flush,
  input  logic                 halt,
  input  logic                 pc_op,
  input  logic                 b_jmp,
  input  logic [15:0]          branch_target,
  input  logic [15:0]          jump_target,
  fetch_stage_if.master        imem,
  output logic [15:0]          if_id_instr,
  output logic [15:0]          if_id_pc2,
  output logic                 if_id_valid,
  output logic                 halted,
  output logic                 fetch_timeout
);
  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [7:0]   wcnt_q, wcnt_d;
  logic         tout_q, tout_d;
  logic         ifid_load, ifid_bubble;
  logic [15:0]  pc_next;

  assign pc_next = pc_plus2(pc_q);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wcnt_d      = wcnt_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;

    if (state_q == HALTED || halt) begin
      state_d     = HALTED;
      ifid_bubble = 1'b1;
    end else if (pc_op) begin
      pc_d        = (b_jmp ? branch_target : jump_target) & 16'hFFFE;
      state_d     = RUN;
      wcnt_d      = 8'd0;
      ifid_bubble = 1'b1;
    end else if (if_flush) begin
      ifid_bubble = 1'b1;
      if (!stall) begin
        if (imem.imem_valid) begin
          pc_d    = pc_next;
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else begin
          state_d = WAIT;
          wcnt_d  = sat_inc8(wcnt_q);
        end
      end
    end else if (stall) begin
      // Full hold: PC, IF/ID, state and wait counter all keep their values.
    end else if (!imem.imem_valid) begin
      state_d     = WAIT;
      wcnt_d      = sat_inc8(wcnt_q);
      ifid_bubble = 1'b1;
    end else begin
      pc_d      = pc_next;
      state_d   = RUN;
      wcnt_d    = 8'd0;
      ifid_load = 1'b1;
    end

    // Sticky: once the memory has been silent too long the error stays latched.
    tout_d = tout_q | (32'(wcnt_d) >= WAIT_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      wcnt_q  <= 8'd0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wcnt_q  <= wcnt_d;
      tout_q  <= tout_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (imem.imem_rdata),
    .pc2_in   (pc_next),
    .instr    (if_id_instr),
    .pc2      (if_id_pc2),
    .valid    (if_id_valid)
  );

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state_q != HALTED);
  assign halted         = (state_q == HALTED);
  assign fetch_timeout  = tout_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, if_flush, halt, pc_op, b_jmp;
  logic [15:0] branch_target, jump_target;
  logic [15:0] if_id_instr, if_id_pc2;
  logic        if_id_valid, halted, fetch_timeout;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC   (16'h0000),
    .NOP_INSTR  (16'h8000),
    .WAIT_LIMIT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .if_flush      (if_flush),
    .halt          (halt),
    .pc_op         (pc_op),
    .b_jmp         (b_jmp),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem          (bus),
    .if_id_instr   (if_id_instr),
    .if_id_pc2     (if_id_pc2),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_timeout (fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; if_flush = 0; halt = 0; pc_op = 0; b_jmp = 0;
    branch_target = 16'h0; jump_target = 16'h0;
    bus.imem_valid = 1'b1; bus.imem_rdata = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    total_cnt++; if (bus.imem_addr !== 16'h0000) $display("FAIL reset_addr got %h want 0000", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (bus.imem_req !== 1'b1) $display("FAIL reset_req got %b want 1", bus.imem_req); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'h8000) $display("FAIL reset_instr got %h want 8000", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_pc2 !== 16'h0000) $display("FAIL reset_pc2 got %h want 0000", if_id_pc2); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else pass_cnt++;
    total_cnt++; if (fetch_timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", fetch_timeout); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    logic [15:0] words [3] = '{16'h1A11, 16'h2B22, 16'h3C33};
    logic [15:0] exp_pc;
    exp_pc = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (bus.imem_addr !== exp_pc) $display("FAIL fetch_addr[%0d] got %h want %h", i, bus.imem_addr, exp_pc); else pass_cnt++;
      bus.imem_valid = 1'b1; bus.imem_rdata = words[i];
      tick();
      exp_pc = exp_pc + 16'd2;
      total_cnt++; if (if_id_instr !== words[i]) $display("FAIL fetch_instr[%0d] got %h want %h", i, if_id_instr, words[i]); else pass_cnt++;
      total_cnt++; if (if_id_pc2 !== exp_pc) $display("FAIL fetch_pc2[%0d] got %h want %h", i, if_id_pc2, exp_pc); else pass_cnt++;
      total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL fetch_valid[%0d] got %b want 1", i, if_id_valid); else pass_cnt++;
    end
    total_cnt++; if (bus.imem_addr !== 16'h0006) $display("FAIL fetch_addr_end got %h want 0006", bus.imem_addr); else pass_cnt++;
  endtask

  task automatic test_branch_stall();
    pc_op = 1; b_jmp = 1; branch_target = 16'h0041; jump_target = 16'h0999; stall = 1;
    bus.imem_rdata = 16'h7777;
    tick();
    total_cnt++; if (bus.imem_addr !== 16'h0040) $display("FAIL branch_addr got %h want 0040", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'h8000) $display("FAIL branch_instr got %h want 8000", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL branch_valid got %b want 0", if_id_valid); else pass_cnt++;
    pc_op = 0; b_jmp = 0;
    tick();
    total_cnt++; if (bus.imem_addr !== 16'h0040) $display("FAIL stall_hold_addr got %h want 0040", bus.imem_addr); else pass_cnt++;
    stall = 0;
  endtask

  task automatic test_jump_flush();
    pc_op = 1; b_jmp = 0; jump_target = 16'h0100; branch_target = 16'h0500;
    tick();
    total_cnt++; if (bus.imem_addr !== 16'h0100) $display("FAIL jump_addr got %h want 0100", bus.imem_addr); else pass_cnt++;
    pc_op = 0; if_flush = 1; bus.imem_valid = 1; bus.imem_rdata = 16'h1234;
    tick();
    total_cnt++; if (bus.imem_addr !== 16'h0102) $display("FAIL flush_addr got %h want 0102", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'h8000) $display("FAIL flush_instr got %h want 8000", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", if_id_valid); else pass_cnt++;
    if_flush = 0; bus.imem_rdata = 16'h5555;
    tick();
    total_cnt++; if (if_id_instr !== 16'h5555) $display("FAIL post_flush_instr got %h want 5555", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_pc2 !== 16'h0104) $display("FAIL post_flush_pc2 got %h want 0104", if_id_pc2); else pass_cnt++;
  endtask

  task automatic test_timeout();
    bus.imem_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total_cnt++; if (bus.imem_addr !== 16'h0104) $display("FAIL wait_addr[%0d] got %h want 0104", i, bus.imem_addr); else pass_cnt++;
      total_cnt++; if (fetch_timeout !== (i >= 8)) $display("FAIL wait_timeout[%0d] got %b want %b", i, fetch_timeout, (i >= 8)); else pass_cnt++;
    end
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL wait_valid got %b want 0", if_id_valid); else pass_cnt++;
    bus.imem_valid = 1; bus.imem_rdata = 16'h6666;
    tick();
    total_cnt++; if (bus.imem_addr !== 16'h0106) $display("FAIL resume_addr got %h want 0106", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'h6666) $display("FAIL resume_instr got %h want 6666", if_id_instr); else pass_cnt++;
    total_cnt++; if (fetch_timeout !== 1'b1) $display("FAIL timeout_sticky got %b want 1", fetch_timeout); else pass_cnt++;
  endtask

  task automatic test_wrap();
    pc_op = 1; b_jmp = 0; jump_target = 16'hFFFE;
    tick();
    pc_op = 0; bus.imem_rdata = 16'hABCD;
    tick();
    total_cnt++; if (bus.imem_addr !== 16'h0000) $display("FAIL wrap_addr got %h want 0000", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_pc2 !== 16'h0000) $display("FAIL wrap_pc2 got %h want 0000", if_id_pc2); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'hABCD) $display("FAIL wrap_instr got %h want abcd", if_id_instr); else pass_cnt++;
  endtask

  task automatic test_halt_reset();
    pc_op = 1; b_jmp = 0; jump_target = 16'h0200;
    tick();
    halt = 1; pc_op = 1; jump_target = 16'h0300;
    tick();
    total_cnt++; if (bus.imem_addr !== 16'h0200) $display("FAIL halt_addr got %h want 0200", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag got %b want 1", halted); else pass_cnt++;
    total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL halt_req got %b want 0", bus.imem_req); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL halt_valid got %b want 0", if_id_valid); else pass_cnt++;
    halt = 0; pc_op = 0; bus.imem_rdata = 16'h4444;
    tick();
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_stays got %b want 1", halted); else pass_cnt++;
    total_cnt++; if (bus.imem_addr !== 16'h0200) $display("FAIL halt_pc_hold got %h want 0200", bus.imem_addr); else pass_cnt++;
    #2 reset = 1;
    #2;
    total_cnt++; if (halted !== 1'b0) $display("FAIL async_halted got %b want 0", halted); else pass_cnt++;
    total_cnt++; if (bus.imem_addr !== 16'h0000) $display("FAIL async_addr got %h want 0000", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (fetch_timeout !== 1'b0) $display("FAIL async_timeout got %b want 0", fetch_timeout); else pass_cnt++;
    reset = 0;
    bus.imem_rdata = 16'h9999;
    tick();
    total_cnt++; if (if_id_instr !== 16'h9999) $display("FAIL after_reset_instr got %h want 9999", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_pc2 !== 16'h0002) $display("FAIL after_reset_pc2 got %h want 0002", if_id_pc2); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch_stall();
    test_jump_flush();
    test_timeout();
    test_wrap();
    test_halt_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
